// File: rtl/leds_display_pkg.sv
// Shared definitions for the memory-mapped LED / seven-segment output peripheral.
package leds_display_pkg;

   // Bus addresses of the three peripheral registers
   localparam logic [31:0] LED_ADDR  = 32'h7000_0010;
   localparam logic [31:0] HEX_ADDR  = 32'h7000_0014;
   localparam logic [31:0] CTRL_ADDR = 32'h7000_0018;

   // Only these bits are stored on a write; everything else reads back as 0
   localparam logic [31:0] LED_MASK  = 32'h0000_03FF;
   localparam logic [31:0] HEX_MASK  = 32'h000F_FFFF;
   localparam logic [31:0] CTRL_MASK = 32'h0000_01FF;

   // CTRL layout: [3:0] bright, [4] disp_en, [8:5] digit_mask
   localparam int CTRL_BRIGHT_LSB  = 0;
   localparam int CTRL_DISP_EN_BIT = 4;
   localparam int CTRL_DMASK_LSB   = 5;

   // Full brightness, display enabled, all four digits enabled
   localparam logic [31:0] CTRL_RESET = 32'h0000_01FF;

   // Offset of the per-digit decimal-point bits inside HEX
   localparam int HEX_DP_LSB = 16;

endpackage

// File: rtl/leds_display_hex_to_7seg.sv
// Hex nibble to seven-segment pattern, active-high, bit order {g,f,e,d,c,b,a}.
module hex_to_7seg (
   input  logic [3:0] nibble,
   output logic [6:0] segments
);

   // Pure lookup of the glyph for each hex digit (lower-case b and d)
   always_comb begin
      segments = 7'h00;
      case (nibble)
         4'h0: segments = 7'h3F;
         4'h1: segments = 7'h06;
         4'h2: segments = 7'h5B;
         4'h3: segments = 7'h4F;
         4'h4: segments = 7'h66;
         4'h5: segments = 7'h6D;
         4'h6: segments = 7'h7D;
         4'h7: segments = 7'h07;
         4'h8: segments = 7'h7F;
         4'h9: segments = 7'h6F;
         4'hA: segments = 7'h77;
         4'hB: segments = 7'h7C;
         4'hC: segments = 7'h39;
         4'hD: segments = 7'h5E;
         4'hE: segments = 7'h79;
         4'hF: segments = 7'h71;
         default: segments = 7'h00;
      endcase
   end

endmodule

// File: rtl/leds_display.sv
// CPU-writable LED bank and 4-digit multiplexed common-anode display with PWM dimming.
module leds_display
   import leds_display_pkg::*;
#(
   parameter int SCAN_DIV = 50000,
   parameter int PWM_BITS = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic [9:0]  led_o,
   output logic [7:0]  seg_no,
   output logic [3:0]  an_no
);

   localparam int PRESC_W = $clog2(SCAN_DIV);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);

   logic [31:0]         led_reg;
   logic [31:0]         hex_reg;
   logic [31:0]         ctrl_reg;
   logic [PRESC_W-1:0]  presc;
   logic [1:0]          digit_idx;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                rd_en_q;
   logic [31:0]         rd_addr_q;

   logic                wr_led;
   logic                wr_hex;
   logic                wr_ctrl;
   logic [PWM_BITS-1:0] bright;
   logic                disp_en;
   logic [3:0]          digit_mask;
   logic [3:0]          dp_bits;
   logic [3:0]          cur_nibble;
   logic [6:0]          cur_glyph;
   logic                pwm_on;
   logic                digit_on;

   assign wr_led  = en_i & we_i & (addr_i == LED_ADDR);
   assign wr_hex  = en_i & we_i & (addr_i == HEX_ADDR);
   assign wr_ctrl = en_i & we_i & (addr_i == CTRL_ADDR);

   assign bright     = ctrl_reg[CTRL_BRIGHT_LSB +: PWM_BITS];
   assign disp_en    = ctrl_reg[CTRL_DISP_EN_BIT];
   assign digit_mask = ctrl_reg[CTRL_DMASK_LSB +: 4];
   assign dp_bits    = hex_reg[HEX_DP_LSB +: 4];
   assign cur_nibble = hex_reg[4*digit_idx +: 4];

   assign pwm_on   = (pwm_cnt <= bright);
   assign digit_on = disp_en & digit_mask[digit_idx] & pwm_on;

   hex_to_7seg u_hex_to_7seg (
      .nibble   (cur_nibble),
      .segments (cur_glyph)
   );

   // Register file: masked writes to whichever register the bus addresses
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         led_reg  <= '0;
         hex_reg  <= '0;
         ctrl_reg <= CTRL_RESET;
      end else begin
         if (wr_led)  led_reg  <= wdata_i & LED_MASK;
         if (wr_hex)  hex_reg  <= wdata_i & HEX_MASK;
         if (wr_ctrl) ctrl_reg <= wdata_i & CTRL_MASK;
      end
   end

   // Digit scan: a CTRL write restarts the scan at digit 0, even on a wrap edge
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         presc     <= '0;
         digit_idx <= '0;
      end else if (wr_ctrl) begin
         presc     <= '0;
         digit_idx <= '0;
      end else if (presc == PRESC_LAST) begin
         presc     <= '0;
         digit_idx <= digit_idx + 2'd1;
      end else begin
         presc     <= presc + 1'b1;
      end
   end

   // Free-running PWM phase counter shared by LEDs and display
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) pwm_cnt <= '0;
      else       pwm_cnt <= pwm_cnt + 1'b1;
   end

   // Capture the bus request so read data appears one cycle later
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
      end else begin
         rd_en_q   <= en_i;
         rd_addr_q <= addr_i;
      end
   end

   // Read mux on the captured request; unknown addresses and idle cycles return 0
   always_comb begin
      rdata_o = '0;
      if (rd_en_q) begin
         case (rd_addr_q)
            LED_ADDR:  rdata_o = led_reg;
            HEX_ADDR:  rdata_o = hex_reg;
            CTRL_ADDR: rdata_o = ctrl_reg;
            default:   rdata_o = '0;
         endcase
      end
   end

   // Registered pin drivers so the outputs are glitch-free
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         led_o  <= '0;
         seg_no <= 8'hFF;
         an_no  <= 4'hF;
      end else begin
         led_o  <= pwm_on ? led_reg[9:0] : 10'd0;
         an_no  <= digit_on ? ~(4'b0001 << digit_idx) : 4'hF;
         seg_no <= digit_on ? ~{dp_bits[digit_idx], cur_glyph} : 8'hFF;
      end
   end

endmodule

// File: tb/tb_leds_display.sv
// Self-checking bench for leds_display with a cycle-count based reference model.
module tb_leds_display;

   localparam int SCAN_DIV = 4;
   localparam logic [31:0] LED_A  = 32'h7000_0010;
   localparam logic [31:0] HEX_A  = 32'h7000_0014;
   localparam logic [31:0] CTRL_A = 32'h7000_0018;
   localparam logic [31:0] BAD_A  = 32'h7000_001C;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        en_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic [9:0]  led_o;
   logic [7:0]  seg_no;
   logic [3:0]  an_no;

   int checks = 0;
   int errors = 0;

   // Reference state: register contents plus edge counts since reset / last CTRL write
   logic [31:0] mLed;
   logic [31:0] mHex;
   logic [31:0] mCtrl;
   int          edgeCnt;
   int          clearEdge;
   logic [6:0]  hex7Tbl [16];

   int          countA;
   int          countB;

   leds_display #(.SCAN_DIV(SCAN_DIV), .PWM_BITS(4)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (en_i),
      .we_i    (we_i),
      .addr_i  (addr_i),
      .wdata_i (wdata_i),
      .rdata_o (rdata_o),
      .led_o   (led_o),
      .seg_no  (seg_no),
      .an_no   (an_no)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] regValue(input logic [31:0] a);
      if (a == LED_A)  return mLed;
      if (a == HEX_A)  return mHex;
      if (a == CTRL_A) return mCtrl;
      return 32'h0;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // What the pins should show one cycle after the current model state
   task automatic expectedPins(output logic [9:0] eLed, output logic [3:0] eAn, output logic [7:0] eSeg);
      int pwm;
      int idx;
      bit pwmOn;
      bit digitOn;
      logic [3:0] sel;
      pwm     = edgeCnt % 16;
      idx     = ((edgeCnt - clearEdge) / SCAN_DIV) % 4;
      pwmOn   = (pwm <= int'(mCtrl[3:0]));
      digitOn = pwmOn && mCtrl[4] && mCtrl[5 + idx];
      sel     = 4'b0001 << idx;
      eLed    = pwmOn ? mLed[9:0] : 10'd0;
      eAn     = digitOn ? ~sel : 4'hF;
      eSeg    = digitOn ? ~{mHex[16 + idx], hex7Tbl[mHex[4*idx +: 4]]} : 8'hFF;
   endtask

   // One bus cycle: drive, clock, advance the model, compare every output
   task automatic applyStimulus(input bit en, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
      logic [9:0]  eLed;
      logic [3:0]  eAn;
      logic [7:0]  eSeg;
      logic [31:0] eRd;
      en_i    = en;
      we_i    = we;
      addr_i  = addr;
      wdata_i = wdata;
      expectedPins(eLed, eAn, eSeg);
      @(posedge clk_i);
      #1;
      edgeCnt++;
      if (en && we) begin
         if (addr == LED_A)  mLed = wdata & 32'h3FF;
         if (addr == HEX_A)  mHex = wdata & 32'hF_FFFF;
         if (addr == CTRL_A) begin
            mCtrl     = wdata & 32'h1FF;
            clearEdge = edgeCnt;
         end
      end
      eRd = en ? regValue(addr) : 32'h0;
      checkOutput("led_o", {22'd0, led_o}, {22'd0, eLed});
      checkOutput("an_no", {28'd0, an_no}, {28'd0, eAn});
      checkOutput("seg_no", {24'd0, seg_no}, {24'd0, eSeg});
      checkOutput("rdata_o", rdata_o, eRd);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic modelReset();
      mLed      = 32'h0;
      mHex      = 32'h0;
      mCtrl     = 32'h1FF;
      edgeCnt   = 0;
      clearEdge = 0;
   endtask

   initial begin
      hex7Tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      rst_i   = 1'b1;
      en_i    = 1'b0;
      we_i    = 1'b0;
      addr_i  = 32'h0;
      wdata_i = 32'h0;
      modelReset();

      // Power-on reset
      repeat (3) @(posedge clk_i);
      #1;
      checkOutput("por_led", {22'd0, led_o}, 32'h0);
      checkOutput("por_an", {28'd0, an_no}, 32'hF);
      checkOutput("por_seg", {24'd0, seg_no}, 32'hFF);
      checkOutput("por_rdata", rdata_o, 32'h0);
      rst_i = 1'b0;
      $display("[TB] reset released");

      // Scan for a while with LEDs lit, then reset asynchronously mid-scan
      applyStimulus(1'b1, 1'b1, LED_A, 32'h0000_0155);
      idle(9);
      #2;
      rst_i = 1'b1;
      #1;
      checkOutput("async_led", {22'd0, led_o}, 32'h0);
      checkOutput("async_an", {28'd0, an_no}, 32'hF);
      checkOutput("async_seg", {24'd0, seg_no}, 32'hFF);
      checkOutput("async_rdata", rdata_o, 32'h0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      modelReset();
      applyStimulus(1'b1, 1'b0, CTRL_A, 32'h0);
      checkOutput("reset_ctrl_read", rdata_o, 32'h0000_01FF);

      // LED write, readback, and read with en_i low
      applyStimulus(1'b1, 1'b1, LED_A, 32'hFFFF_FFFF);
      applyStimulus(1'b1, 1'b0, LED_A, 32'h0);
      checkOutput("led_all_on", {22'd0, led_o}, 32'h3FF);
      checkOutput("led_readback", rdata_o, 32'h0000_03FF);
      applyStimulus(1'b0, 1'b0, LED_A, 32'h0);
      checkOutput("read_no_en", rdata_o, 32'h0);

      // Digit scan, restarted by the CTRL write
      applyStimulus(1'b1, 1'b1, HEX_A, 32'h0001_1234);
      applyStimulus(1'b1, 1'b1, CTRL_A, 32'h0000_01FF);
      idle(1);
      checkOutput("digit0_an", {28'd0, an_no}, 32'hE);
      checkOutput("digit0_seg", {24'd0, seg_no}, 32'h19);
      idle(4);
      checkOutput("digit1_an", {28'd0, an_no}, 32'hD);
      checkOutput("digit1_seg", {24'd0, seg_no}, 32'hB0);
      idle(8);
      checkOutput("digit3_an", {28'd0, an_no}, 32'h7);
      checkOutput("digit3_seg", {24'd0, seg_no}, 32'hF9);
      idle(4);
      checkOutput("digit0_again_an", {28'd0, an_no}, 32'hE);

      // Brightness 3: lit on 4 of every 16 cycles; brightness 0: 1 of 16
      applyStimulus(1'b1, 1'b1, CTRL_A, 32'h0000_01F3);
      countA = 0;
      for (int i = 0; i < 16; i++) begin
         idle(1);
         if (led_o != 10'd0) countA++;
      end
      checkOutput("bright3_duty", countA, 32'd4);
      applyStimulus(1'b1, 1'b1, CTRL_A, 32'h0000_01F0);
      countA = 0;
      for (int i = 0; i < 16; i++) begin
         idle(1);
         if (led_o != 10'd0) countA++;
      end
      checkOutput("bright0_duty", countA, 32'd1);

      // Digit mask 0101 with display on: digits 1 and 3 stay dark
      applyStimulus(1'b1, 1'b1, CTRL_A, 32'h0000_00BF);
      countA = 0;
      for (int i = 0; i < 16; i++) begin
         idle(1);
         if (an_no == 4'hF && seg_no == 8'hFF) countA++;
      end
      checkOutput("mask_dark_cycles", countA, 32'd8);
      applyStimulus(1'b1, 1'b1, CTRL_A, 32'h0000_00AF);
      idle(8);

      // Display disabled: digits dark, LEDs still full on
      applyStimulus(1'b1, 1'b1, CTRL_A, 32'h0000_01EF);
      countA = 0;
      countB = 0;
      for (int i = 0; i < 16; i++) begin
         idle(1);
         if (an_no == 4'hF && seg_no == 8'hFF) countA++;
         if (led_o == 10'h3FF) countB++;
      end
      checkOutput("disp_off_dark", countA, 32'd16);
      checkOutput("disp_off_leds", countB, 32'd16);

      // Unmapped address: write ignored, read returns 0
      applyStimulus(1'b1, 1'b1, BAD_A, 32'hFFFF_FFFF);
      applyStimulus(1'b1, 1'b0, BAD_A, 32'h0);
      checkOutput("bad_addr_read", rdata_o, 32'h0);
      applyStimulus(1'b1, 1'b0, LED_A, 32'h0);
      checkOutput("led_after_bad", rdata_o, 32'h0000_03FF);

      // CTRL write landing exactly on a prescaler wrap into digit 2
      applyStimulus(1'b1, 1'b1, CTRL_A, 32'h0000_01FF);
      idle(7);
      applyStimulus(1'b1, 1'b1, CTRL_A, 32'h0000_01FF);
      idle(1);
      checkOutput("wrap_write_idx0", {28'd0, an_no}, 32'hE);

      // HEX write is masked to 20 bits
      applyStimulus(1'b1, 1'b1, HEX_A, 32'hFFFF_FFFF);
      applyStimulus(1'b1, 1'b0, HEX_A, 32'h0);
      checkOutput("hex_mask_read", rdata_o, 32'h000F_FFFF);

      // Randomized bus traffic against the model
      for (int i = 0; i < 600; i++) begin
         int unsigned sel;
         logic [31:0] a;
         logic [31:0] d;
         bit en;
         bit we;
         sel = $urandom_range(0, 19);
         if (sel < 6)       a = LED_A;
         else if (sel < 12) a = HEX_A;
         else if (sel < 14) a = CTRL_A;
         else if (sel < 16) a = BAD_A;
         else               a = $urandom();
         d  = $urandom();
         en = ($urandom_range(0, 3) != 0);
         we = ($urandom_range(0, 1) == 1);
         if (a == CTRL_A && $urandom_range(0, 1) == 1) d[4] = 1'b1;
         applyStimulus(en, we, a, d);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
